// File: rtl/cmd_frame_parser.sv
// Byte-stream command frame parser: header sync, checksum, tail check and
// inter-byte timeout, emitting one registered command per good frame.
module cmd_frame_parser #(
   parameter logic [7:0] HEAD0          = 8'h55,
   parameter logic [7:0] HEAD1          = 8'hA5,
   parameter logic [7:0] TAIL           = 8'hF0,
   parameter int         TIMEOUT_CYCLES = 500000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_done,
   output logic        cmdvalid,
   output logic [7:0]  cmd_addr,
   output logic [31:0] cmd_data,
   output logic        frame_err,
   output logic        timeout_err
);

   localparam int CW =
      (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   // Fires on the idle cycle that would take the count to TIMEOUT_CYCLES-1
   localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES - 2);

   typedef enum logic [2:0] {
      S_H0, S_H1, S_ADDR, S_DATA, S_SUM, S_TAIL
   } state_t;

   state_t        state;
   logic [1:0]    idx;
   logic [7:0]    acc;
   logic [7:0]    sh_addr;
   logic [31:0]   sh_data;
   logic [CW-1:0] tcnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_H0;
         idx         <= '0;
         acc         <= '0;
         sh_addr     <= '0;
         sh_data     <= '0;
         tcnt        <= '0;
         cmdvalid    <= 1'b0;
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
         cmd_addr    <= '0;
         cmd_data    <= '0;
      end else begin
         cmdvalid    <= 1'b0;
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
         if (rx_done) begin
            tcnt <= '0;
            unique case (state)
               S_H0: begin
                  if (rx_data == HEAD0) state <= S_H1;
               end
               S_H1: begin
                  if (rx_data == HEAD1) state <= S_ADDR;
                  else if (rx_data != HEAD0) state <= S_H0;
               end
               S_ADDR: begin
                  sh_addr <= rx_data;
                  acc     <= rx_data;
                  idx     <= '0;
                  state   <= S_DATA;
               end
               S_DATA: begin
                  sh_data <= {sh_data[23:0], rx_data};
                  acc     <= acc + rx_data;
                  if (idx == 2'd3) state <= S_SUM;
                  else idx <= idx + 2'd1;
               end
               S_SUM: begin
                  if (rx_data == acc) begin
                     state <= S_TAIL;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= S_H0;
                  end
               end
               S_TAIL: begin
                  if (rx_data == TAIL) begin
                     cmd_addr <= sh_addr;
                     cmd_data <= sh_data;
                     cmdvalid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  state <= S_H0;
               end
               default: state <= S_H0;
            endcase
         end else if (state != S_H0) begin
            if (tcnt == TLIM) begin
               timeout_err <= 1'b1;
               state       <= S_H0;
               tcnt        <= '0;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Self-checking bench for cmd_frame_parser: vector table, directed corner
// sequences and random frames against a queue-based frame model.
module tb_cmd_frame_parser;

   localparam int TO = 100;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_done;
   logic        cmdvalid;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_data;
   logic        frame_err;
   logic        timeout_err;

   cmd_frame_parser #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
      .cmdvalid(cmdvalid), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .frame_err(frame_err), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: bytes of the frame in progress and idle time
   logic [7:0]  q[$];
   int          idle = 0;
   logic        e_v, e_fe, e_te;
   logic [7:0]  m_addr = 8'h00;
   logic [31:0] m_data = 32'h0;

   int          nv = 0, nfe = 0, nte = 0;
   logic [7:0]  o_addr;
   logic [31:0] o_data;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic model(input bit r, input bit d, input logic [7:0] b);
      logic [7:0] s;
      e_v = 0; e_fe = 0; e_te = 0;
      if (r) begin
         q.delete(); idle = 0; m_addr = 0; m_data = 0;
      end else if (d) begin
         idle = 0;
         if (q.size() == 0) begin
            if (b == 8'h55) q.push_back(b);
         end else if (q.size() == 1) begin
            if (b == 8'hA5) q.push_back(b);
            else if (b != 8'h55) q.delete();
         end else begin
            q.push_back(b);
            if (q.size() == 8) begin
               s = q[2] + q[3] + q[4] + q[5] + q[6];
               if (s != q[7]) begin e_fe = 1; q.delete(); end
            end else if (q.size() == 9) begin
               if (b == 8'hF0) begin
                  e_v = 1; m_addr = q[2];
                  m_data = {q[3], q[4], q[5], q[6]};
               end else e_fe = 1;
               q.delete();
            end
         end
      end else if (q.size() > 0) begin
         idle++;
         if (idle == TO - 1) begin e_te = 1; q.delete(); idle = 0; end
      end
   endtask

   // One clock: drive at negedge, compare after the following posedge
   task automatic cyc(input bit r, input bit d, input logic [7:0] b);
      reset = r; rx_done = d; rx_data = d ? b : 8'($urandom);
      model(r, d, b);
      @(negedge clk);
      chk("cmdvalid", cmdvalid, e_v);
      chk("frame_err", frame_err, e_fe);
      chk("timeout_err", timeout_err, e_te);
      chk("cmd_addr", cmd_addr, m_addr);
      chk("cmd_data", cmd_data, m_data);
      if (cmdvalid) begin nv++; o_addr = cmd_addr; o_data = cmd_data; end
      if (frame_err) nfe++;
      if (timeout_err) nte++;
   endtask

   task automatic send(input logic [7:0] b); cyc(0, 1, b); endtask
   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 8'h00);
   endtask

   typedef struct {
      logic [95:0] bytes;
      int          len;
      int          gap;
      int          kind;
      logic [7:0]  addr;
      logic [31:0] data;
   } vec_t;

   vec_t vt[7];

   initial begin
      int b_v, b_fe, b_te;
      logic [7:0] fr[$];
      logic [7:0] a, s;
      logic [31:0] dd;

      vt[0] = '{96'h55A5_02_00001000_12_F0, 9, 0, 1, 8'h02, 32'h00001000};
      vt[1] = '{96'h55A5_01_00000003_05_F0, 9, 0, 2, 8'h02, 32'h00001000};
      vt[2] = '{96'h55A5_01_00000003_04_F0, 9, 3, 1, 8'h01, 32'h00000003};
      vt[3] = '{96'h3355_55A5_03_01020304_0D_F0, 11, 0, 1,
                8'h03, 32'h01020304};
      vt[4] = '{96'h3355_55A5_03_01020304_0D_F1, 11, 2, 2,
                8'h03, 32'h01020304};
      vt[5] = '{96'h55A5_10_DEADBEEF_48_F0, 9, 0, 1, 8'h10, 32'hDEADBEEF};
      vt[6] = '{96'h55A5_20_01020304_2A_F0, 9, 0, 1, 8'h20, 32'h01020304};

      reset = 1; rx_done = 0; rx_data = 0;
      cyc(1, 0, 8'h00);
      cyc(1, 0, 8'h00);
      idle_n(2);

      foreach (vt[k]) begin
         b_v = nv; b_fe = nfe;
         for (int i = 0; i < vt[k].len; i++)
            send(vt[k].bytes[8*(vt[k].len-1-i) +: 8]);
         idle_n(vt[k].gap);
         chk($sformatf("vec%0d_valid_cnt", k), nv - b_v,
             (vt[k].kind == 1) ? 1 : 0);
         chk($sformatf("vec%0d_ferr_cnt", k), nfe - b_fe,
             (vt[k].kind == 2) ? 1 : 0);
         chk($sformatf("vec%0d_addr", k), cmd_addr, vt[k].addr);
         chk($sformatf("vec%0d_data", k), cmd_data, vt[k].data);
      end

      // Timeout fires exactly 99 idle cycles after the last strobe
      b_te = nte;
      send(8'h55); send(8'hA5); send(8'h01); send(8'h00);
      idle_n(98);
      chk("to_early", nte - b_te, 0);
      idle_n(1);
      chk("to_fire", timeout_err, 1'b1);
      idle_n(3);

      // Byte on the 99th cycle beats the timeout
      b_te = nte; b_v = nv;
      send(8'h55); send(8'hA5); send(8'h01); send(8'h00);
      idle_n(98);
      send(8'h00); send(8'h00); send(8'h03); send(8'h04); send(8'hF0);
      idle_n(2);
      chk("to_race_none", nte - b_te, 0);
      chk("to_race_valid", nv - b_v, 1);
      chk("to_race_data", o_data, 32'h00000003);

      // Reset mid-frame
      send(8'h55); send(8'hA5); send(8'h00);
      cyc(1, 0, 8'h00);
      chk("rst_addr", cmd_addr, 8'h00);
      chk("rst_data", cmd_data, 32'h0);
      b_v = nv;
      send(8'h55); send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
      send(8'h00); send(8'h01); send(8'h01); send(8'hF0);
      chk("rst_valid", nv - b_v, 1);
      chk("rst_frame_addr", o_addr, 8'h00);
      chk("rst_frame_data", o_data, 32'h00000001);
      idle_n(2);

      // Random frames with corruption, noise and long gaps
      for (int n = 0; n < 150; n++) begin
         fr.delete();
         if ($urandom_range(7) == 0) fr.push_back(8'($urandom));
         if ($urandom_range(7) == 0) fr.push_back(8'h55);
         a = 8'($urandom); dd = $urandom;
         s = a + dd[31:24] + dd[23:16] + dd[15:8] + dd[7:0];
         if ($urandom_range(5) == 0) s = s ^ 8'(1 << $urandom_range(7));
         fr.push_back(8'h55); fr.push_back(8'hA5); fr.push_back(a);
         fr.push_back(dd[31:24]); fr.push_back(dd[23:16]);
         fr.push_back(dd[15:8]); fr.push_back(dd[7:0]); fr.push_back(s);
         fr.push_back(($urandom_range(5) == 0) ? 8'hF1 : 8'hF0);
         foreach (fr[i]) begin
            if ($urandom_range(9) == 0) idle_n($urandom_range(95, 104));
            else idle_n($urandom_range(0, 1));
            send(fr[i]);
         end
         idle_n($urandom_range(0, 2));
      end
      idle_n(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
